// File: rtl/mux2_1_stream_arbiter.sv
// Two-input round-robin stream merger with bounded bursts and a one-entry registered output.
// S tags each Y beat with its source (0 = A1, 1 = A2) so Y/S can feed a 1:2 demux directly.
module mux2_1_stream_arbiter #(
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] A1,
    input  logic         V1,
    output logic         R1,
    input  logic [W-1:0] A2,
    input  logic         V2,
    output logic         R2,
    output logic [W-1:0] Y,
    output logic         VY,
    input  logic         RY,
    output logic         S,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_y;
    logic          r_s;
    logic          r_vy;

    logic w_ld;
    logic w_r1;
    logic w_r2;
    logic w_acc1;
    logic w_acc2;
    logic w_burst_end;
    logic w_rel1;
    logic w_rel2;

    // Handshake: a beat moves on any edge where valid && ready; a producer holds
    // data/valid until that edge, and ready never waits on the producer's valid.
    assign w_ld        = !r_vy || RY;
    assign w_r1        = (r_state == GNT1) && w_ld;
    assign w_r2        = (r_state == GNT2) && w_ld;
    assign w_acc1      = V1 && w_r1;
    assign w_acc2      = V2 && w_r2;
    assign w_burst_end = (r_cnt == CNT_LAST);
    assign w_rel1      = !V1 || (w_acc1 && w_burst_end);
    assign w_rel2      = !V2 || (w_acc2 && w_burst_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_y     <= '0;
            r_s     <= 1'b0;
            r_vy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    // A tie goes to whichever input was not granted last.
                    if (V1 && (!V2 || r_last)) begin
                        r_state <= GNT1;
                        r_last  <= 1'b0;
                    end else if (V2) begin
                        r_state <= GNT2;
                        r_last  <= 1'b1;
                    end
                end
                GNT1: begin
                    if (w_rel1) begin
                        r_cnt <= '0;
                        if (V2) begin
                            r_state <= GNT2;
                            r_last  <= 1'b1;
                        end else if (V1) begin
                            r_state <= GNT1;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_acc1) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                GNT2: begin
                    if (w_rel2) begin
                        r_cnt <= '0;
                        if (V1) begin
                            r_state <= GNT1;
                            r_last  <= 1'b0;
                        end else if (V2) begin
                            r_state <= GNT2;
                            r_last  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_acc2) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase

            // Output register: load on acceptance, drop VY once the consumer takes it.
            if (w_acc1) begin
                r_y  <= A1;
                r_s  <= 1'b0;
                r_vy <= 1'b1;
            end else if (w_acc2) begin
                r_y  <= A2;
                r_s  <= 1'b1;
                r_vy <= 1'b1;
            end else if (RY) begin
                r_vy <= 1'b0;
            end
        end
    end

    assign R1        = w_r1;
    assign R2        = w_r2;
    assign Y         = r_y;
    assign VY        = r_vy;
    assign S         = r_s;
    assign dbg_state = r_state;

endmodule
